// File: rtl/opsum_gon_collector.sv
// opsum_gon_collector: drains GON FIFO words lane by lane into sequential GLB writes for F*e*m psums.
// Optional OPSUM_RELU_EN adds a last_pass input that clamps negative psums to zero on write.
module opsum_gon_collector #(
  parameter int F_WIDTH       = 6,
  parameter int e_WIDTH       = 8,
  parameter int m_WIDTH       = 8,
  parameter int DATA_WIDTH    = 16,
  parameter int FIFO_IN_WIDTH = 64,
  parameter int ADDR_WIDTH    = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [F_WIDTH-1:0]       F,
  input  logic [e_WIDTH-1:0]       e,
  input  logic [m_WIDTH-1:0]       m,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
`ifdef OPSUM_RELU_EN
  input  logic                     last_pass,
`endif
  input  logic                     gon_fifo_empty,
  output logic                     re_from_gon,
  input  logic [FIFO_IN_WIDTH-1:0] din,
  input  logic                     glb_busy,
  output logic                     we_to_glb,
  output logic [ADDR_WIDTH-1:0]    opsum_addr,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     busy,
  output logic                     done
);
  localparam int LANES = FIFO_IN_WIDTH / DATA_WIDTH;
  localparam int LW    = LANES > 1 ? $clog2(LANES) : 1;
  localparam int TW    = F_WIDTH + e_WIDTH + m_WIDTH;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAIN, FINISH} state_t;
  state_t                   state, state_n;
  logic [TW-1:0]            total, total_in, cnt;
  logic [ADDR_WIDTH-1:0]    addr;
  logic [LW-1:0]            idx;
  logic [FIFO_IN_WIDTH-1:0] lane;
  logic [DATA_WIDTH-1:0]    val;
  logic                     last;
  assign total_in    = TW'(F) * TW'(e) * TW'(m);
  assign val         = lane[int'(idx) * DATA_WIDTH +: DATA_WIDTH];
  assign last        = (cnt + TW'(1)) == total;
  assign re_from_gon = state == FETCH && !gon_fifo_empty;
  assign we_to_glb   = state == DRAIN && !glb_busy;
  assign busy        = state != IDLE;
  assign done        = state == FINISH;
  assign opsum_addr  = addr;
`ifdef OPSUM_RELU_EN
  logic relu;
  assign dout = (state == DRAIN && !(relu && val[DATA_WIDTH-1])) ? val : '0;
`else
  assign dout = state == DRAIN ? val : '0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = total_in == '0 ? FINISH : FETCH;
      FETCH:   if (!gon_fifo_empty) state_n = WAIT;
      WAIT:    state_n = DRAIN;
      DRAIN:   if (!glb_busy) state_n = last ? FINISH : idx == LW'(LANES - 1) ? FETCH : DRAIN;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      total <= '0;
      cnt   <= '0;
      addr  <= '0;
      idx   <= '0;
      lane  <= '0;
`ifdef OPSUM_RELU_EN
      relu  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        total <= total_in;
        addr  <= base_addr;
        cnt   <= '0;
`ifdef OPSUM_RELU_EN
        relu  <= last_pass;
`endif
      end
      if (state == WAIT) begin
        lane <= din;
        idx  <= '0;
      end
      // lanes past the final element are never written; FINISH simply abandons them
      if (we_to_glb) begin
        addr <= addr + ADDR_WIDTH'(1);
        cnt  <= cnt + TW'(1);
        idx  <= idx + LW'(1);
      end
    end
  end
endmodule

// File: tb/tb_opsum_gon_collector.sv
// tb_opsum_gon_collector: randomized and directed checks against a flattened-lane write-list model.
module tb_opsum_gon_collector;
  logic        clk = 0, reset = 0, start = 0;
  logic [5:0]  F = 0;
  logic [7:0]  e = 0, m = 0;
  logic [19:0] base_addr = 0;
  logic        gon_fifo_empty = 1, re_from_gon, glb_busy = 0, we_to_glb, busy, done;
  logic [63:0] din = 0;
  logic [19:0] opsum_addr;
  logic [15:0] dout;
`ifdef OPSUM_RELU_EN
  logic        last_pass = 0;
`endif
  opsum_gon_collector dut (
    .clk(clk), .reset(reset), .start(start), .F(F), .e(e), .m(m), .base_addr(base_addr),
`ifdef OPSUM_RELU_EN
    .last_pass(last_pass),
`endif
    .gon_fifo_empty(gon_fifo_empty), .re_from_gon(re_from_gon), .din(din), .glb_busy(glb_busy),
    .we_to_glb(we_to_glb), .opsum_addr(opsum_addr), .dout(dout), .busy(busy), .done(done));
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0, cyc = 0, wi = 0, ndone = 0, done_cyc = 0;
  int busy_pct = 0, empty_pct = 0, stall_left = 0;
  bit force_empty = 0, stall_trig = 0, pop_pend = 0;
  logic [63:0] q[$], pop_word;
  logic [15:0] exp_d[$];
  logic [19:0] exp_a[$], last_wr_addr;
  int wr_cyc[$];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (pop_pend) din = pop_word;
    pop_pend = 0;
    glb_busy = stall_left > 0 ? 1'b1 : ($urandom_range(99) < busy_pct);
    if (stall_left > 0) stall_left--;
    gon_fifo_empty = force_empty || q.size() == 0 || ($urandom_range(99) < empty_pct);
    @(negedge clk);
    if (re_from_gon || we_to_glb) check("re_we_excl", re_from_gon & we_to_glb, 0);
    if (glb_busy && busy) check("stall_no_we", we_to_glb, 0);
    if (gon_fifo_empty) check("empty_no_re", re_from_gon, 0);
    if (we_to_glb) begin
      if (wi < exp_d.size()) begin
        check("wr_data", dout, exp_d[wi]);
        check("wr_addr", opsum_addr, exp_a[wi]);
      end else check("write_count", wi + 1, exp_d.size());
      last_wr_addr = opsum_addr;
      wr_cyc.push_back(cyc);
      wi++;
      if (stall_trig && wi == 1) begin
        stall_left = 3;
        stall_trig = 0;
      end
    end
    if (re_from_gon) begin
      if (q.size() > 0) pop_word = q.pop_front();
      pop_pend = 1;
    end
    if (done) begin
      ndone++;
      done_cyc = cyc;
    end
  endtask
  task automatic begin_pass(input int f, input int ee, input int mm, input logic [19:0] ba, input bit lp);
    int total = f * ee * mm;
    logic [63:0] w;
    logic [15:0] v;
    exp_d.delete(); exp_a.delete(); wr_cyc.delete();
    wi = 0; ndone = 0;
    for (int i = 0; i < total; i++) begin
      w = q[i / 4];
      v = w[(i % 4) * 16 +: 16];
      exp_d.push_back((lp && v[15]) ? 16'h0 : v);
      exp_a.push_back(ba + 20'(i));
    end
    F = 6'(f); e = 8'(ee); m = 8'(mm); base_addr = ba;
`ifdef OPSUM_RELU_EN
    last_pass = lp;
`endif
    start = 1;
    cycle();
    start = 0;
  endtask
  task automatic finish_pass(input bit poke);
    int n = 0;
    while (ndone == 0 && n < 5000) begin
      if (poke) begin
        start = ($urandom_range(9) == 0);
        F = 6'($urandom);
      end
      cycle();
      n++;
    end
    start = 0;
    check("done_seen", ndone, 1);
    cycle();
    check("done_once", ndone, 1);
    check("busy_after", busy, 0);
    check("write_count", wi, exp_d.size());
    if (wr_cyc.size() > 0) check("done_after_last", done_cyc - wr_cyc[$], 1);
  endtask
  initial begin
    repeat (2) cycle();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_re", re_from_gon, 0);
    check("rst_we", we_to_glb, 0);
    check("rst_addr", opsum_addr, 0);
    check("rst_dout", dout, 0);
    reset = 1;
    cycle();
    // four lanes from one word, consecutive writes
    q.push_back(64'h0004_0003_0002_0001);
    begin_pass(2, 2, 1, 20'h100, 0);
    finish_pass(0);
    if (wr_cyc.size() == 4) check("consecutive", wr_cyc[3] - wr_cyc[0], 3);
    check("last_addr_028", last_wr_addr, 20'h103);
    // total 6 over two words, trailing lanes discarded
    q.push_back(64'h1111_2222_3333_4444); q.push_back(64'h5555_6666_7777_8888);
    begin_pass(3, 1, 2, 20'h2A0, 0);
    finish_pass(0);
    check("last_addr_029", last_wr_addr, 20'h2A5);
    check("fifo_left", q.size(), 0);
    // glb stall of three cycles on lane 1
    q.push_back(64'hDEAD_BEEF_CAFE_F00D);
    stall_trig = 1;
    begin_pass(4, 1, 1, 20'h040, 0);
    finish_pass(0);
    if (wr_cyc.size() == 4) check("stall_gap", wr_cyc[1] - wr_cyc[0], 4);
    // FIFO empty for ten cycles after start
    q.push_back(64'h0123_4567_89AB_CDEF);
    force_empty = 1;
    begin_pass(1, 2, 2, 20'h500, 0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("empty_busy", busy, 1);
      check("empty_we", we_to_glb, 0);
    end
    force_empty = 0;
    cycle();
    check("pop_on_ready", re_from_gon, 1);
    finish_pass(0);
    // zero total goes straight to FINISH
    F = 0; e = 3; m = 3; start = 1; ndone = 0;
    cycle();
    start = 0;
    check("zero_done", done, 1);
    check("zero_re", re_from_gon, 0);
    cycle();
    check("zero_done_end", done, 0);
    check("zero_idle", busy, 0);
    // reset in the middle of DRAIN
    q.push_back(64'h4444_3333_2222_1111);
    begin_pass(4, 1, 1, 20'h777, 0);
    for (int i = 0; i < 50 && wi < 2; i++) cycle();
    check("mid_reached", wi, 2);
    reset = 0;
    cycle();
    reset = 1;
    check("mrst_busy", busy, 0);
    check("mrst_we", we_to_glb, 0);
    check("mrst_re", re_from_gon, 0);
    check("mrst_done", done, 0);
    check("mrst_addr", opsum_addr, 0);
    check("mrst_dout", dout, 0);
    repeat (5) cycle();
    check("mrst_no_done", ndone, 0);
    check("mrst_no_more", wi, 2);
    // randomized passes with stalls, empty gaps, address wrap and stray starts
    busy_pct = 30; empty_pct = 20;
    for (int p = 0; p < 12; p++) begin
      int f = $urandom_range(1, 3), ee = $urandom_range(1, 3), mm = $urandom_range(1, 3);
      logic [19:0] ba = (p % 3 == 0) ? 20'hFFFF0 + 20'($urandom_range(15)) : 20'($urandom);
      for (int k = 0; k < (f * ee * mm + 3) / 4; k++) q.push_back({$urandom, $urandom});
`ifdef OPSUM_RELU_EN
      begin_pass(f, ee, mm, ba, 1'($urandom));
`else
      begin_pass(f, ee, mm, ba, 0);
`endif
      finish_pass(1);
    end
`ifdef OPSUM_RELU_EN
    busy_pct = 0; empty_pct = 0;
    q.push_back(64'h0005_8000_7FFF_FFF0);
    begin_pass(4, 1, 1, 20'h10, 1);
    finish_pass(0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
